// File: rtl/mode_ac_pkg.sv
// Shared Mode A/C timing package.
// Holds the pulse-timing constants (in 61.44 MHz clocks) and the mode codes used by both the
// interrogation detector and the interrogation generator, so both sides agree on frame timing.
// Also holds the generator state type.
package mode_ac_pkg;

    // Pulse timing in sample clocks.
    localparam int unsigned MODE_AC_PW      = 49;    // 0.8 us pulse width
    localparam int unsigned MODE_AC_P2_OFF  = 123;   // P2 leading edge after P1 (2 us)
    localparam int unsigned MODE_AC_P3A_OFF = 492;   // Mode A P3 offset (8 us)
    localparam int unsigned MODE_AC_P3C_OFF = 1290;  // Mode C P3 offset (21 us)

    // Frame-time counter width; large enough for the longest legal frame.
    localparam int unsigned MODE_AC_CNT_W = 16;

    // Mode codes reported by the detector.
    localparam logic [7:0] MODE_AC_CODE_A = 8'h01;
    localparam logic [7:0] MODE_AC_CODE_C = 8'h02;

    typedef enum logic {
        StIdle,
        StRun
    } gen_state_e;

endpackage

// File: rtl/mode_ac_intr_generator_if.sv
// Mode A/C interrogation generator bus.
// Request side: start, mode_c, p2_en, p1_amp, p2_amp, abort.
// Response side: busy, pulse_on, rise_out, amp_out, done.
// master: frame requester (drives the request side).
// slave : the generator (drives the response side).
interface mode_ac_intr_generator_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic             mode_c;
    logic             p2_en;
    logic [WIDTH-1:0] p1_amp;
    logic [WIDTH-1:0] p2_amp;
    logic             abort;
    logic             busy;
    logic             pulse_on;
    logic             rise_out;
    logic [WIDTH-1:0] amp_out;
    logic             done;

    modport master (
        output start, mode_c, p2_en, p1_amp, p2_amp, abort,
        input  busy, pulse_on, rise_out, amp_out, done
    );

    modport slave (
        input  start, mode_c, p2_en, p1_amp, p2_amp, abort,
        output busy, pulse_on, rise_out, amp_out, done
    );

endinterface

// File: rtl/mode_ac_ramp.sv
// Pulse envelope scaler.
// Scales a peak amplitude by the ramp factor for pulse-relative time j:
//   f = j+1 on the rising ramp, PW-j on the falling ramp, RAMP on the flat top,
//   amp = (A * f) >> RAMP_SHIFT, so the flat top is exactly A.
// Ports:
//   i_amp : peak amplitude A
//   i_j   : cycle index within the pulse (0 .. PW-1)
//   o_amp : scaled envelope amplitude
module mode_ac_ramp
    import mode_ac_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned PW         = MODE_AC_PW,
    parameter int unsigned RAMP_SHIFT = 2,
    parameter int unsigned CNT_W      = MODE_AC_CNT_W
) (
    input  logic [WIDTH-1:0] i_amp,
    input  logic [CNT_W-1:0] i_j,
    output logic [WIDTH-1:0] o_amp
);
    localparam int unsigned     RAMP   = 1 << RAMP_SHIFT;
    localparam int unsigned     PROD_W = WIDTH + RAMP_SHIFT;
    localparam logic [CNT_W-1:0] C_RAMP = CNT_W'(RAMP);
    localparam logic [CNT_W-1:0] C_TAIL = CNT_W'(PW - RAMP);
    localparam logic [CNT_W-1:0] C_PW   = CNT_W'(PW);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    logic [CNT_W-1:0]  w_f;
    logic [PROD_W-1:0] w_prod;

    always_comb begin
        if (i_j < C_RAMP) begin
            w_f = i_j + C_ONE;
        end else if (i_j >= C_TAIL) begin
            w_f = C_PW - i_j;
        end else begin
            w_f = C_RAMP;
        end
    end

    // f never exceeds RAMP, so A*f fits in WIDTH+RAMP_SHIFT bits.
    assign w_prod = PROD_W'(i_amp) * PROD_W'(w_f);
    assign o_amp  = WIDTH'(w_prod >> RAMP_SHIFT);

endmodule

// File: rtl/mode_ac_intr_generator.sv
// SSR Mode A/C interrogation frame generator.
// One start request produces P1, an optional P2 (SLS) pulse and P3 at the Mode A or Mode C
// offset, each with a ramped amplitude envelope and a 1-cycle rise strobe. Frame time t=0 is
// the cycle after the accepted start; done pulses at t = P3_OFF+PW with the block back in idle.
// Ports:
//   clk : system clock (61.44 MHz sample clock)
//   rst : asynchronous active-high reset
//   bus : generator bus (slave side): start/mode_c/p2_en/p1_amp/p2_amp/abort in,
//         busy/pulse_on/rise_out/amp_out/done out
module mode_ac_intr_generator
    import mode_ac_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned PW         = MODE_AC_PW,
    parameter int unsigned P2_OFF     = MODE_AC_P2_OFF,
    parameter int unsigned P3A_OFF    = MODE_AC_P3A_OFF,
    parameter int unsigned P3C_OFF    = MODE_AC_P3C_OFF,
    parameter int unsigned RAMP_SHIFT = 2
) (
    input logic                     clk,
    input logic                     rst,
    mode_ac_intr_generator_if.slave bus
);
    localparam int unsigned      CW       = MODE_AC_CNT_W;
    localparam logic [CW-1:0]    C_PW     = CW'(PW);
    localparam logic [CW-1:0]    C_P2     = CW'(P2_OFF);
    localparam logic [CW-1:0]    C_P2_END = CW'(P2_OFF + PW);
    localparam logic [CW-1:0]    C_P3A    = CW'(P3A_OFF);
    localparam logic [CW-1:0]    C_P3C    = CW'(P3C_OFF);
    localparam logic [CW-1:0]    C_LAST_A = CW'(P3A_OFF + PW - 1);
    localparam logic [CW-1:0]    C_LAST_C = CW'(P3C_OFF + PW - 1);

    gen_state_e       r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_done;
    logic             r_mode_c;
    logic             r_p2_en;
    logic [WIDTH-1:0] r_p1_amp;
    logic [WIDTH-1:0] r_p2_amp;

    logic             w_run;
    logic [CW-1:0]    w_p3_off;
    logic [CW-1:0]    w_last;
    logic             w_in_p1;
    logic             w_in_p2;
    logic             w_in_p3;
    logic             w_pulse;
    logic [CW-1:0]    w_j;
    logic [WIDTH-1:0] w_amp_sel;
    logic [WIDTH-1:0] w_ramp_amp;

    // Frame sequencer. done is a registered strobe raised on the cycle the state returns to
    // idle; a start seen in that same cycle is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_done   <= 1'b0;
            r_mode_c <= 1'b0;
            r_p2_en  <= 1'b0;
            r_p1_amp <= '0;
            r_p2_amp <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (bus.start && !bus.abort && !r_done) begin
                        r_mode_c <= bus.mode_c;
                        r_p2_en  <= bus.p2_en;
                        r_p1_amp <= bus.p1_amp;
                        r_p2_amp <= bus.p2_amp;
                        r_cnt    <= '0;
                        r_state  <= StRun;
                    end
                end
                StRun: begin
                    if (bus.abort) begin
                        r_cnt   <= '0;
                        r_state <= StIdle;
                    end else if (r_cnt == w_last) begin
                        r_cnt   <= '0;
                        r_done  <= 1'b1;
                        r_state <= StIdle;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign w_run    = (r_state == StRun);
    assign w_p3_off = r_mode_c ? C_P3C : C_P3A;
    assign w_last   = r_mode_c ? C_LAST_C : C_LAST_A;

    // Windows cannot overlap for legal offsets. The P3 upper bound is implicit: RUN never
    // holds a count past the last P3 cycle.
    assign w_in_p1 = (r_cnt < C_PW);
    assign w_in_p2 = r_p2_en && (r_cnt >= C_P2) && (r_cnt < C_P2_END);
    assign w_in_p3 = (r_cnt >= w_p3_off);
    assign w_pulse = w_run && (w_in_p1 || w_in_p2 || w_in_p3);

    always_comb begin
        w_j       = r_cnt;
        w_amp_sel = r_p1_amp;
        if (w_in_p2) begin
            w_j       = r_cnt - C_P2;
            w_amp_sel = r_p2_amp;
        end else if (w_in_p3) begin
            w_j = r_cnt - w_p3_off;
        end
    end

    mode_ac_ramp #(
        .WIDTH      (WIDTH),
        .PW         (PW),
        .RAMP_SHIFT (RAMP_SHIFT),
        .CNT_W      (CW)
    ) u_ramp (
        .i_amp (w_amp_sel),
        .i_j   (w_j),
        .o_amp (w_ramp_amp)
    );

    // Outputs decode only registered state, so reset clears them immediately.
    assign bus.busy     = w_run;
    assign bus.pulse_on = w_pulse;
    assign bus.rise_out = w_pulse && (w_j == '0);
    assign bus.amp_out  = w_pulse ? w_ramp_amp : '0;
    assign bus.done     = r_done;

endmodule

// File: doc/mode_ac_intr_generator.md
Name: mode_ac_intr_generator

Overview:
- Transmit-side counterpart of the Mode A/C interrogation detector. Generates one SSR Mode A or Mode C interrogation frame per start request: P1, an optional P2 side-lobe-suppression pulse, and P3.
- Drives a ramped amplitude envelope plus a 1-cycle rise strobe per pulse.
- Pulse timing in clocks matches the detector windows (61.44 MHz sample clock). The block feeds the TX DAC path and the internal loopback test path into the detector.

Parameters:
- WIDTH, 16, amplitude width.
- PW, 49, pulse width in clocks (0.8 us).
- P2_OFF, 123, P2 leading edge relative to P1 (2 us).
- P3A_OFF, 492, Mode A P3 offset (8 us).
- P3C_OFF, 1290, Mode C P3 offset (21 us).
- RAMP_SHIFT, 2, ramp length RAMP = 2**RAMP_SHIFT clocks.
- Legal range: PW >= 2*RAMP; P2_OFF >= PW; P3A_OFF >= P2_OFF+PW.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  1-cycle frame request
- mode_c  in  1  0 = Mode A, 1 = Mode C
- p2_en  in  1  emit P2 pulse
- p1_amp  in  WIDTH  peak amplitude for P1 and P3
- p2_amp  in  WIDTH  peak amplitude for P2
- abort  in  1  synchronous frame cancel
- busy  out  1  frame in progress
- pulse_on  out  1  envelope gate, high on every cycle of an active pulse
- rise_out  out  1  1-cycle strobe on the first cycle of each pulse
- amp_out  out  WIDTH  ramped envelope amplitude
- done  out  1  1-cycle frame-complete strobe

Behaviour:
- Reset (async) clears state to IDLE and cnt to 0. All outputs reset to 0.
- States: IDLE, RUN.
- IDLE:
  - start=1 latches mode_c, p2_en, p1_amp and p2_amp.
  - Next state is RUN with cnt=0. Frame time t=0 is the first cycle after the start cycle.
  - No outputs are asserted in IDLE except done (see below).
- RUN:
  - Outputs at frame time t are a function of cnt=t.
  - cnt increments by 1 each cycle. cnt is 16 bits; it cannot wrap within legal parameters.
- Pulse windows (offset O): P1 O=0; P2 O=P2_OFF, only if latched p2_en; P3 O=P3A_OFF or P3C_OFF by latched mode.
- Pulse active when O <= t <= O+PW-1, with j = t-O.
- While a pulse is active:
  - pulse_on=1.
  - rise_out=1 only at j=0.
  - Ramp factor f = j+1 for j < RAMP; f = PW-j for j >= PW-RAMP; otherwise f = RAMP.
  - amp_out = (A*f) >> RAMP_SHIFT, computed at WIDTH+RAMP_SHIFT bits and then truncated. Result is exactly A when f = RAMP.
  - A = latched p2_amp for P2, latched p1_amp otherwise.
- Outside pulses: pulse_on=0, rise_out=0, amp_out=0.
- Frame end: at t = P3_OFF+PW, done=1 for one cycle and busy=0. The state returns to IDLE in that cycle; done is the only output asserted.
- busy=1 for t = 0 .. P3_OFF+PW-1.
- Latency:
  - start to first rise_out: 1 cycle.
  - Mode A frame: start to done = P3A_OFF+PW+1 clocks (542).
  - Mode C frame: 1340 clocks.
- start while busy is ignored; no queueing. start in the same cycle as done is also ignored; the next frame needs start with busy=0 in IDLE.
- abort in RUN: next cycle is IDLE with all outputs 0 and no done. abort wins over start when both are asserted.
- Input changes during RUN have no effect, because all inputs are latched at start.
- p2_amp > 0.75*p1_amp models a side-lobe transmission; the detector rejects it. The generator does not check this.

Decomposition:
- Shared package mode_ac_pkg holds P2_OFF, P3A_OFF, P3C_OFF, PW and the mode codes (A=8'h01, C=8'h02). The detector and this generator both use these so their timing is shared.
- One sub-module, mode_ac_ramp: a combinational/registered scaler that takes (amplitude, j, PW) and produces amp_out.

Test Plan:
- Mode A, p1_amp=16'h4000, p2_en=1, p2_amp=16'h2000:
  - rise_out at t = 0, 123, 492.
  - amp_out at t = 0..3 is 1000, 2000, 3000, 4000 (hex).
  - amp_out at t = 45..48 is 4000, 3000, 2000, 1000.
  - P2 peak is 2000. done at t = 541.
- Mode C, p2_en=0: rise_out only at t = 0 and 1290; pulse_on low for t = 49..1289; done at t = 1339.
- Loopback into the detector, Mode A frame, p2_amp=16'h1000: detector msg_data low byte 8'h01. With p2_amp=16'h3800 (> 0.75*4000): no msg_valid.
- start pulsed at t = 100 and at the done cycle: both ignored; exactly one done per accepted start.
- abort at t = 200: next cycle busy=0 and amp_out=0; no done. A new start is accepted afterwards.
- rst asserted asynchronously mid-pulse (t = 10): all outputs 0 immediately. After release, a fresh start gives rise_out 1 cycle later.
